// File: rtl/rv_pkg.sv
// Shared RV32I definitions: ALU control codes, opcodes and operand selects.
package rv_pkg;

    typedef logic [4:0] alu_op_t;

    localparam alu_op_t ALU_ADD  = 5'd0;
    localparam alu_op_t ALU_SUB  = 5'd1;
    localparam alu_op_t ALU_SLL  = 5'd2;
    localparam alu_op_t ALU_SLT  = 5'd3;
    localparam alu_op_t ALU_SLTU = 5'd4;
    localparam alu_op_t ALU_XOR  = 5'd5;
    localparam alu_op_t ALU_SRL  = 5'd6;
    localparam alu_op_t ALU_SRA  = 5'd7;
    localparam alu_op_t ALU_OR   = 5'd8;
    localparam alu_op_t ALU_AND  = 5'd9;
    localparam alu_op_t ALU_BEQ  = 5'd10;
    localparam alu_op_t ALU_BNE  = 5'd11;
    localparam alu_op_t ALU_BLT  = 5'd12;
    localparam alu_op_t ALU_BGE  = 5'd13;
    localparam alu_op_t ALU_BLTU = 5'd14;
    localparam alu_op_t ALU_BGEU = 5'd15;
    localparam alu_op_t ALU_PASS = 5'd16;

    localparam logic [6:0] OP_RTYPE  = 7'b0110011;
    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;

    typedef enum logic {
        RS1 = 1'b0,
        PC  = 1'b1
    } in1_sel_t;

    typedef enum logic [1:0] {
        RS2  = 2'd0,
        IMM  = 2'd1,
        FOUR = 2'd2,
        ZERO = 2'd3
    } in2_sel_t;

    // Arithmetic/logic mapping shared by R-type and I-ALU; sub_ok selects
    // whether funct7 bit 5 turns funct3 0 into SUB (R-type only).
    function automatic alu_op_t arith_op(input logic [2:0] funct3,
                                         input logic       funct7_b5,
                                         input logic       sub_ok);
        alu_op_t op;
        case (funct3)
            3'd0:    op = (sub_ok && funct7_b5) ? ALU_SUB : ALU_ADD;
            3'd1:    op = ALU_SLL;
            3'd2:    op = ALU_SLT;
            3'd3:    op = ALU_SLTU;
            3'd4:    op = ALU_XOR;
            3'd5:    op = funct7_b5 ? ALU_SRA : ALU_SRL;
            3'd6:    op = ALU_OR;
            default: op = ALU_AND;
        endcase
        return op;
    endfunction

endpackage

// File: rtl/id_ex_stage_alu_decoder.sv
// Combinational opcode/funct decode into ALU code and operand selects.
module alu_decoder
    import rv_pkg::*;
(
    input  logic [6:0] opcode,
    input  logic [2:0] funct3,
    input  logic       funct7_b5,
    output alu_op_t    alu_op,
    output in1_sel_t   in1_sel,
    output in2_sel_t   in2_sel,
    output logic       is_branch,
    output logic       illegal
);

    // Decode table; anything unrecognised becomes an illegal PASS of zero.
    always_comb begin
        alu_op    = ALU_PASS;
        in1_sel   = RS1;
        in2_sel   = ZERO;
        is_branch = 1'b0;
        illegal   = 1'b0;
        case (opcode)
            OP_RTYPE: begin
                alu_op  = arith_op(funct3, funct7_b5, 1'b1);
                in2_sel = RS2;
            end
            OP_IMM: begin
                alu_op  = arith_op(funct3, funct7_b5, 1'b0);
                in2_sel = IMM;
            end
            OP_LOAD, OP_STORE: begin
                alu_op  = ALU_ADD;
                in2_sel = IMM;
            end
            OP_BRANCH: begin
                is_branch = 1'b1;
                in2_sel   = RS2;
                case (funct3)
                    3'd0:    alu_op = ALU_BEQ;
                    3'd1:    alu_op = ALU_BNE;
                    3'd4:    alu_op = ALU_BLT;
                    3'd5:    alu_op = ALU_BGE;
                    3'd6:    alu_op = ALU_BLTU;
                    3'd7:    alu_op = ALU_BGEU;
                    default: begin
                        alu_op  = ALU_PASS;
                        illegal = 1'b1;
                    end
                endcase
            end
            OP_LUI: begin
                alu_op  = ALU_PASS;
                in2_sel = IMM;
            end
            OP_AUIPC: begin
                alu_op  = ALU_ADD;
                in1_sel = PC;
                in2_sel = IMM;
            end
            OP_JAL, OP_JALR: begin
                // ALU produces the link address pc + 4
                alu_op  = ALU_ADD;
                in1_sel = PC;
                in2_sel = FOUR;
            end
            default: begin
                alu_op  = ALU_PASS;
                in2_sel = ZERO;
                illegal = 1'b1;
            end
        endcase
    end

endmodule

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with ALU decode and MEM/WB operand forwarding.
module id_ex_stage
    import rv_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        stall,
    input  logic        flush,
    input  logic        id_valid,
    input  logic        id_reg_write,
    input  logic [31:0] id_pc,
    input  logic [31:0] id_rs1_data,
    input  logic [31:0] id_rs2_data,
    input  logic [31:0] id_imm,
    input  logic [4:0]  id_rs1_addr,
    input  logic [4:0]  id_rs2_addr,
    input  logic [4:0]  id_rd_addr,
    input  logic [6:0]  id_opcode,
    input  logic [2:0]  id_funct3,
    input  logic        id_funct7_b5,
    input  logic        mem_fwd_en,
    input  logic        wb_fwd_en,
    input  logic [4:0]  mem_rd_addr,
    input  logic [4:0]  wb_rd_addr,
    input  logic [31:0] mem_fwd_data,
    input  logic [31:0] wb_fwd_data,
    output logic        id_ready,
    output logic        ex_valid,
    output logic        ex_reg_write,
    output logic        ex_is_branch,
    output logic        ex_illegal,
    output logic [31:0] ex_pc,
    output logic [4:0]  ex_rd_addr,
    output logic [31:0] alu_in1,
    output logic [31:0] alu_in2,
    output logic [4:0]  alu_ctrl,
    output logic [31:0] ex_store_data
);

    alu_op_t     dec_alu_op;
    in1_sel_t    dec_in1_sel;
    in2_sel_t    dec_in2_sel;
    logic        dec_is_branch;
    logic        dec_illegal;

    logic        valid_reg;
    logic        reg_write_reg;
    logic        is_branch_reg;
    logic        illegal_reg;
    logic [31:0] pc_reg;
    logic [31:0] imm_reg;
    logic [31:0] rs1_data_reg;
    logic [31:0] rs2_data_reg;
    logic [4:0]  rs1_addr_reg;
    logic [4:0]  rs2_addr_reg;
    logic [4:0]  rd_addr_reg;
    alu_op_t     alu_op_reg;
    in1_sel_t    in1_sel_reg;
    in2_sel_t    in2_sel_reg;

    logic [31:0] rs1_fwd;
    logic [31:0] rs2_fwd;
    logic        capture_live;

    alu_decoder u_dec (
        .opcode    (id_opcode),
        .funct3    (id_funct3),
        .funct7_b5 (id_funct7_b5),
        .alu_op    (dec_alu_op),
        .in1_sel   (dec_in1_sel),
        .in2_sel   (dec_in2_sel),
        .is_branch (dec_is_branch),
        .illegal   (dec_illegal)
    );

    // MEM beats WB; x0 is never forwarded.
    function automatic logic [31:0] fwd_sel(input logic [4:0]  rs,
                                            input logic [31:0] reg_data,
                                            input logic        m_en,
                                            input logic [4:0]  m_rd,
                                            input logic [31:0] m_data,
                                            input logic        w_en,
                                            input logic [4:0]  w_rd,
                                            input logic [31:0] w_data);
        logic [31:0] r;
        if (m_en && (m_rd == rs) && (rs != 5'd0))
            r = m_data;
        else if (w_en && (w_rd == rs) && (rs != 5'd0))
            r = w_data;
        else
            r = reg_data;
        return r;
    endfunction

    assign id_ready     = !stall;
    assign capture_live = id_valid && !flush;

    // Operand forwarding and ALU input selection from the registered fields.
    always_comb begin
        rs1_fwd = fwd_sel(rs1_addr_reg, rs1_data_reg, mem_fwd_en, mem_rd_addr,
                          mem_fwd_data, wb_fwd_en, wb_rd_addr, wb_fwd_data);
        rs2_fwd = fwd_sel(rs2_addr_reg, rs2_data_reg, mem_fwd_en, mem_rd_addr,
                          mem_fwd_data, wb_fwd_en, wb_rd_addr, wb_fwd_data);
        alu_in1 = (in1_sel_reg == PC) ? pc_reg : rs1_fwd;
        case (in2_sel_reg)
            RS2:     alu_in2 = rs2_fwd;
            IMM:     alu_in2 = imm_reg;
            FOUR:    alu_in2 = 32'd4;
            default: alu_in2 = 32'd0;
        endcase
    end

    assign ex_valid      = valid_reg;
    assign ex_reg_write  = reg_write_reg;
    assign ex_is_branch  = is_branch_reg;
    assign ex_illegal    = illegal_reg;
    assign ex_pc         = pc_reg;
    assign ex_rd_addr    = rd_addr_reg;
    assign alu_ctrl      = alu_op_reg;
    assign ex_store_data = rs2_fwd;

    // Stage register: flush beats stall; a stall refreshes operand data so a
    // producer retiring from WB during the stall is kept.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_reg     <= 1'b0;
            reg_write_reg <= 1'b0;
            is_branch_reg <= 1'b0;
            illegal_reg   <= 1'b0;
            pc_reg        <= 32'd0;
            imm_reg       <= 32'd0;
            rs1_data_reg  <= 32'd0;
            rs2_data_reg  <= 32'd0;
            rs1_addr_reg  <= 5'd0;
            rs2_addr_reg  <= 5'd0;
            rd_addr_reg   <= 5'd0;
            alu_op_reg    <= ALU_ADD;
            in1_sel_reg   <= RS1;
            in2_sel_reg   <= RS2;
        end else if (stall && !flush) begin
            rs1_data_reg  <= rs1_fwd;
            rs2_data_reg  <= rs2_fwd;
        end else begin
            valid_reg     <= capture_live;
            reg_write_reg <= capture_live && id_reg_write && !dec_is_branch && !dec_illegal;
            is_branch_reg <= capture_live && dec_is_branch;
            illegal_reg   <= capture_live && dec_illegal;
            pc_reg        <= id_pc;
            imm_reg       <= id_imm;
            rs1_data_reg  <= id_rs1_data;
            rs2_data_reg  <= id_rs2_data;
            rs1_addr_reg  <= id_rs1_addr;
            rs2_addr_reg  <= id_rs2_addr;
            rd_addr_reg   <= id_rd_addr;
            alu_op_reg    <= dec_alu_op;
            in1_sel_reg   <= dec_in1_sel;
            in2_sel_reg   <= dec_in2_sel;
        end
    end

endmodule
